// File: rtl/spike_aer_encoder.sv
`default_nettype none
// ============================================================================
// Module  : spike_aer_encoder
// Brief   : Collects neuron spikes, round-robin arbitrates them and queues
//           {neuron index, timestep} AER events in a first-word-fall-through FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module spike_aer_encoder #(
    parameter int NUM_NEURONS = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TS_WIDTH    = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_NEURONS-1:0]         spike_in,
    input  logic                           tick_in,
    output logic [$clog2(NUM_NEURONS)-1:0] aer_addr,
    output logic [TS_WIDTH-1:0]            aer_time,
    output logic                           aer_valid,
    input  logic                           aer_ready,
    output logic                           busy,
    output logic [7:0]                     drop_count
);
    localparam int c_ADDR_W = $clog2(NUM_NEURONS);
    localparam int c_NUM_W  = c_ADDR_W + 1;
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

    logic [TS_WIDTH-1:0]    r_ts_count;
    logic [NUM_NEURONS-1:0] r_pending;
    logic [c_ADDR_W-1:0]    r_rr_ptr;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [7:0]             r_drop_count;
    logic [c_ADDR_W-1:0]    r_fifo_addr [FIFO_DEPTH];
    logic [TS_WIDTH-1:0]    r_fifo_time [FIFO_DEPTH];

    logic                   w_found;
    logic [c_ADDR_W-1:0]    w_sel;
    logic [c_ADDR_W-1:0]    w_idx;
    logic                   w_full;
    logic                   w_grant;
    logic                   w_pop;
    logic [NUM_NEURONS-1:0] w_grant_onehot;
    logic [NUM_NEURONS-1:0] w_drop_bits;
    logic [c_NUM_W-1:0]     w_drop_num;
    logic [9:0]             w_drop_sum;
    logic [7:0]             w_drop_next;

    // Round-robin search: first pending bit at or above the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            w_idx = r_rr_ptr + c_ADDR_W'(k);
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_full  = (r_count == c_FULL);
    assign w_grant = w_found && !w_full;
    assign w_pop   = (r_count != '0) && aer_ready;

    always_comb begin
        w_grant_onehot = '0;
        if (w_grant) begin
            w_grant_onehot[w_sel] = 1'b1;
        end
    end

    // A spike landing on an already-pending, ungranted neuron is merged and lost.
    assign w_drop_bits = spike_in & r_pending & ~w_grant_onehot;

    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            w_drop_num = w_drop_num + c_NUM_W'(w_drop_bits[i]);
        end
    end

    assign w_drop_sum  = 10'(r_drop_count) + 10'(w_drop_num);
    assign w_drop_next = (w_drop_sum > 10'd255) ? 8'hFF : w_drop_sum[7:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ts_count   <= '0;
            r_pending    <= '0;
            r_rr_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_drop_count <= '0;
        end else begin
            if (tick_in) begin
                r_ts_count <= r_ts_count + TS_WIDTH'(1);
            end
            r_pending    <= (r_pending & ~w_grant_onehot) | spike_in;
            r_drop_count <= w_drop_next;
            if (w_grant) begin
                r_rr_ptr <= w_sel + c_ADDR_W'(1);
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_grant && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_grant && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_fifo_addr[r_wr_ptr] <= w_sel;
            r_fifo_time[r_wr_ptr] <= r_ts_count;
        end
    end

    assign aer_valid  = (r_count != '0);
    assign aer_addr   = aer_valid ? r_fifo_addr[r_rd_ptr] : '0;
    assign aer_time   = aer_valid ? r_fifo_time[r_rd_ptr] : '0;
    assign busy       = (r_pending != '0) || (r_count != '0);
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_spike_aer_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_spike_aer_encoder
// Brief   : Table vectors, directed corner sequences and random traffic
//           checked against a queue-based event model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spike_aer_encoder;
    localparam int N  = 8;
    localparam int D  = 8;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  spike_in = '0;
    logic          tick_in = 1'b0;
    logic [2:0]    aer_addr;
    logic [TW-1:0] aer_time;
    logic          aer_valid;
    logic          aer_ready = 1'b0;
    logic          busy;
    logic [7:0]    drop_count;

    always #5 clk = ~clk;

    spike_aer_encoder #(.NUM_NEURONS(N), .FIFO_DEPTH(D), .TS_WIDTH(TW)) dut (
        .clk(clk), .reset_n(reset_n), .spike_in(spike_in), .tick_in(tick_in),
        .aer_addr(aer_addr), .aer_time(aer_time), .aer_valid(aer_valid),
        .aer_ready(aer_ready), .busy(busy), .drop_count(drop_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct { int addr; int tstamp; } ev_t;
    ev_t    m_q[$];
    bit [N-1:0] m_pend;
    int     m_rr, m_ts, m_drop;

    typedef struct {
        logic [N-1:0] sp; logic tk; logic rd;
        logic ev; int ea; int et; logic eb; int ed;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend = '0;
        m_rr = 0; m_ts = 0; m_drop = 0;
    endtask

    // One clock edge of the reference: arbitrate, pop, push, merge spikes, tick.
    task automatic model_edge(input bit [N-1:0] sp, input bit tk, input bit rd);
        int g = -1;
        if (m_q.size() < D) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        if (m_q.size() > 0 && rd) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back('{g, m_ts});
            m_rr = (g + 1) % N;
            m_pend[g] = 1'b0;
        end
        for (int i = 0; i < N; i++) if (sp[i] && m_pend[i]) m_drop++;
        if (m_drop > 255) m_drop = 255;
        m_pend |= sp;
        if (tk) m_ts = (m_ts + 1) % (1 << TW);
    endtask

    task automatic model_check();
        chk("valid", int'(aer_valid), int'(m_q.size() != 0));
        chk("busy", int'(busy), int'((m_pend != '0) || (m_q.size() != 0)));
        chk("drop_count", int'(drop_count), m_drop);
        if (m_q.size() != 0) begin
            chk("addr", int'(aer_addr), m_q[0].addr);
            chk("time", int'(aer_time), m_q[0].tstamp);
        end
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic cycle(input logic [N-1:0] sp, input logic tk, input logic rd);
        spike_in = sp; tick_in = tk; aer_ready = rd;
        @(posedge clk);
        model_edge(sp, tk, rd);
        @(negedge clk);
        model_check();
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_valid", int'(aer_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(drop_count), 0);
        chk("rst_addr", int'(aer_addr), 0);
        chk("rst_time", int'(aer_time), 0);
        model_reset();
        spike_in = '0; tick_in = 1'b0; aer_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic fill_fifo();
        cycle(8'hFF, 1'b0, 1'b0);
        repeat (8) cycle(8'h00, 1'b0, 1'b0);
    endtask

    int got[16];
    int n_got;
    int n_two;

    initial begin
        // ts_count to 5, then a single spike on neuron 3
        tbl[0] = '{8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0};
        tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0};
        tbl[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0};
        tbl[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0};
        tbl[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0};
        tbl[5] = '{8'h08, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 0};
        tbl[6] = '{8'h00, 1'b0, 1'b1, 1'b1, 3, 5, 1'b1, 0};
        tbl[7] = '{8'h00, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].sp, tbl[i].tk, tbl[i].rd);
            chk($sformatf("tbl%0d_valid", i), int'(aer_valid), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].eb));
            chk($sformatf("tbl%0d_drop", i), int'(drop_count), tbl[i].ed);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_addr", i), int'(aer_addr), tbl[i].ea);
                chk($sformatf("tbl%0d_time", i), int'(aer_time), tbl[i].et);
            end
        end

        // All neurons at once from rr_ptr=0: addresses drain in order
        do_reset();
        cycle(8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle(8'h00, 1'b0, 1'b1);
            chk("rr_order", aer_valid ? int'(aer_addr) : -1, i);
        end
        chk("rr_drops", int'(drop_count), 0);

        // Full FIFO holds the late spike in pending without dropping it
        do_reset();
        fill_fifo();
        cycle(8'h01, 1'b0, 1'b0);
        repeat (3) cycle(8'h00, 1'b0, 1'b0);
        chk("full_count", int'(dut.r_count), 8);
        chk("full_pending", int'(dut.r_pending), 1);
        n_got = 0;
        for (int i = 0; i < 12; i++) begin
            if (aer_valid) begin got[n_got] = int'(aer_addr); n_got++; end
            cycle(8'h00, 1'b0, 1'b1);
        end
        chk("full_events", n_got, 9);
        for (int i = 0; i < 9; i++) chk($sformatf("full_ev%0d", i), got[i], i % 8);
        chk("full_drops", int'(drop_count), 0);

        // Repeated spike on neuron 2 while full: two drops, one extra event
        do_reset();
        fill_fifo();
        repeat (3) cycle(8'h04, 1'b0, 1'b0);
        chk("merge_drops", int'(drop_count), 2);
        n_two = 0;
        for (int i = 0; i < 12; i++) begin
            if (aer_valid && aer_addr == 3'd2) n_two++;
            cycle(8'h00, 1'b0, 1'b1);
        end
        chk("merge_n2_events", n_two, 2);

        // Saturation of the drop counter
        do_reset();
        fill_fifo();
        repeat (40) cycle(8'hFF, 1'b0, 1'b0);
        chk("sat_drop", int'(drop_count), 255);
        repeat (5) cycle(8'hFF, 1'b0, 1'b0);
        chk("sat_hold", int'(drop_count), 255);

        // Reset with queued events, then first-event latency after release
        do_reset();
        cycle(8'h1F, 1'b0, 1'b0);
        repeat (6) cycle(8'h00, 1'b0, 1'b0);
        chk("pre_rst_count", int'(dut.r_count), 5);
        do_reset();
        repeat (3) cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h02, 1'b0, 1'b1);
        chk("lat_k_valid", int'(aer_valid), 0);
        cycle(8'h00, 1'b0, 1'b1);
        chk("lat_k1_valid", int'(aer_valid), 1);
        chk("lat_k1_addr", int'(aer_addr), 1);
        chk("lat_k1_time", int'(aer_time), 0);

        // Random traffic with varying back-pressure
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            for (int c = 0; c < 500; c++) begin
                logic [N-1:0] sp;
                logic tk, rd;
                sp = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
                tk = ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 5) < blk);
                cycle(sp, tk, rd);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spike_aer_encoder.md
SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 SHALL have parameter NUM_NEURONS, 8, number of neuron spike_out lines collected (power of 2, 2..64).
REQ-002 SHALL have parameter FIFO_DEPTH, 8, event FIFO entries (power of 2, 2..64).
REQ-003 SHALL have parameter TS_WIDTH, 8, timestep counter and event timestamp width.
REQ-004 SHALL use a single clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port spike_in  input  NUM_NEURONS  one spike_out per LIF neuron, bit i = neuron i.
REQ-008 SHALL have port tick_in  input  1  timestep advance strobe, one clk wide.
REQ-009 SHALL have port aer_addr  output  log2(NUM_NEURONS)  neuron index of head event.
REQ-010 SHALL have port aer_time  output  TS_WIDTH  timestamp of head event.
REQ-011 SHALL have port aer_valid  output  1  head event present.
REQ-012 SHALL have port aer_ready  input  1  consumer accepts head event.
REQ-013 SHALL have port busy  output  1  pending spikes or FIFO non-empty.
REQ-014 SHALL have port drop_count  output  8  saturating count of lost spikes.

Function
REQ-015 SHALL keep ts_count (TS_WIDTH): +1 on each edge with tick_in=1, wrap max->0.
REQ-016 SHALL keep pending[NUM_NEURONS]: each edge, pending_next = (pending & ~grant_onehot) | spike_in.
REQ-017 SHALL count a drop when spike_in[i]=1, pending[i]=1 and bit i not granted that cycle; spike merged, one drop per such bit per cycle.
REQ-018 SHALL not count a drop when bit i is granted and spike_in[i]=1 in the same cycle; pending[i] stays 1 (new event).
REQ-019 SHALL arbitrate round-robin: search pending from rr_ptr upward mod NUM_NEURONS; grant the first set bit only when FIFO not full.
REQ-020 SHALL set rr_ptr = (granted index + 1) mod NUM_NEURONS after a grant; rr_ptr unchanged without grant.
REQ-021 SHALL push {granted index, ts_count before this edge's increment} into the FIFO on the grant edge; at most one push per cycle.
REQ-022 SHALL, when FIFO full, grant nothing; pending bits held, not dropped.
REQ-023 SHALL pop the head on an edge with aer_valid=1 and aer_ready=1.
REQ-024 SHALL judge full from count before the edge; push and pop on the same edge when not full, count unchanged.
REQ-025 SHALL drive aer_valid = (count != 0) and aer_addr/aer_time from head entry, first-word-fall-through, stable while aer_valid=1 and aer_ready=0.
REQ-026 SHALL have latency: spike_in high before edge k -> pending at edge k -> push at edge k+1 (empty FIFO, no competitors) -> aer_valid=1 after edge k+1.
REQ-027 SHALL drive busy = (pending != 0) | (count != 0), combinational from registers.
REQ-028 SHALL saturate drop_count at 255; incrementing by number of drops in the cycle, clamped.
REQ-029 SHALL ignore aer_ready while aer_valid=0; no pop of empty FIFO.
REQ-030 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.

Reset
REQ-031 SHALL, on reset_n low, asynchronously clear ts_count, pending, rr_ptr, FIFO pointers, count, drop_count; aer_valid=0, busy=0, aer_addr=0, aer_time=0.
REQ-032 SHALL discard all pending and queued events on reset mid-operation; first event after release follows REQ-026.

Verification
REQ-033 SHALL cover: ts_count=5, spike_in=8'h08 one cycle, aer_ready=1 -> aer_valid 1 cycle after two edges, aer_addr=3, aer_time=5, busy falls after pop.
REQ-034 SHALL cover: spike_in=8'hFF one cycle, rr_ptr=0, aer_ready=1 -> addresses 0..7 in order on 8 consecutive cycles, drop_count=0.
REQ-035 SHALL cover: aer_ready=0, spike_in=8'hFF cycle 1 and 8'h01 cycle 10 -> FIFO holds 0..7 (full), pending=8'h00 then 8'h01 held; aer_ready=1 -> 9 events, no drops.
REQ-036 SHALL cover: FIFO full, spike_in[2]=1 on 3 consecutive cycles -> drop_count=2, one event for neuron 2 later.
REQ-037 SHALL cover: 300 drops forced -> drop_count=255, holds.
REQ-038 SHALL cover: 5 events queued, reset_n low mid-cycle -> aer_valid, busy, drop_count 0 immediately; no stale events after release.
